// File: rtl/sram_read_cache_pkg.sv
// Shared types, geometry and address decode for the direct-mapped read cache.
`timescale 1ns/1ps
package sram_read_cache_pkg;

   localparam int unsigned SETS    = 64;
   localparam int unsigned INDEX_W = $clog2(SETS);
   localparam int unsigned ADDR_W  = 17;
   localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
   localparam int unsigned CNT_W   = 16;
   localparam logic [31:0] BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [INDEX_W-1:0] index;
   } addr_split_t;

   // Rebase the byte address onto data-memory word 0 and split the word address.
   function automatic addr_split_t split_addr(input logic [31:0] byte_addr);
      logic [31:0] off;
      addr_split_t res;
      off = byte_addr - BASE_ADDR;
      res = addr_split_t'(off[ADDR_W+1:2]);
      return res;
   endfunction

endpackage

// File: rtl/sram_cache_array.sv
// Valid/tag/data storage: asynchronous lookup, synchronous line write.
`timescale 1ns/1ps
module sram_cache_array
   import sram_read_cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] index,
   input  logic [TAG_W-1:0]   tag,
   input  logic               we,
   input  logic [31:0]        wdata,
   output logic               hit,
   output logic [31:0]        rdata
);

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags  [SETS];
   logic [31:0]      lines [SETS];

   // Valid bits are the only state that must be cleared on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if (we) begin
         valid[index] <= 1'b1;
      end
   end

   // Tag and data payload; contents are meaningless until the line is valid.
   always_ff @(posedge clk) begin
      if (we) begin
         tags[index]  <= tag;
         lines[index] <= wdata;
      end
   end

   assign hit   = valid[index] && (tags[index] == tag);
   assign rdata = lines[index];

endmodule

// File: rtl/sram_read_cache.sv
// Write-through direct-mapped read cache between the MEM stage and the SRAM controller.
`timescale 1ns/1ps
module sram_read_cache
   import sram_read_cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             MEM_R_EN,
   input  logic             MEM_W_EN,
   input  logic [31:0]      ALU_Res,
   input  logic [31:0]      Val_Rm,
   output logic [31:0]      out,
   output logic             ready,
   output logic             sram_r_en,
   output logic             sram_w_en,
   output logic [31:0]      sram_addr,
   output logic [31:0]      sram_wdata,
   input  logic [31:0]      sram_rdata,
   input  logic             sram_ready,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   state_t      state;
   state_t      next_state;
   addr_split_t addr;
   logic        hit;
   logic [31:0] line_data;
   logic        arr_we;
   logic [31:0] arr_wdata;
   logic        hit_inc;
   logic        miss_inc;
   logic        is_wr;
   logic        is_rd;

   assign addr       = split_addr(ALU_Res);
   assign sram_addr  = ALU_Res;
   assign sram_wdata = Val_Rm;
   // A simultaneous load/store request is treated as a store.
   assign is_wr      = MEM_W_EN;
   assign is_rd      = MEM_R_EN & ~MEM_W_EN;

   sram_cache_array u_array (
      .clk   (clk),
      .rst   (rst),
      .index (addr.index),
      .tag   (addr.tag),
      .we    (arr_we),
      .wdata (arr_wdata),
      .hit   (hit),
      .rdata (line_data)
   );

   // Next state, handshake outputs and line-write control; reset forces idle outputs.
   always_comb begin
      next_state = state;
      out        = '0;
      ready      = 1'b1;
      sram_r_en  = 1'b0;
      sram_w_en  = 1'b0;
      arr_we     = 1'b0;
      arr_wdata  = sram_rdata;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (is_wr) begin
               ready      = 1'b0;
               sram_w_en  = 1'b1;
               next_state = WR_THRU;
            end else if (is_rd) begin
               if (hit) begin
                  out     = line_data;
                  hit_inc = 1'b1;
               end else begin
                  ready      = 1'b0;
                  sram_r_en  = 1'b1;
                  miss_inc   = 1'b1;
                  next_state = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            sram_r_en = 1'b1;
            ready     = sram_ready;
            if (sram_ready) begin
               out        = sram_rdata;
               arr_we     = 1'b1;
               arr_wdata  = sram_rdata;
               next_state = IDLE;
            end
         end
         WR_THRU: begin
            sram_w_en = 1'b1;
            ready     = sram_ready;
            if (sram_ready) begin
               // No write-allocate: only a resident line picks up the store data.
               arr_we     = hit;
               arr_wdata  = Val_Rm;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (!rst) begin
         next_state = IDLE;
         out        = '0;
         ready      = 1'b1;
         sram_r_en  = 1'b0;
         sram_w_en  = 1'b0;
         arr_we     = 1'b0;
         hit_inc    = 1'b0;
         miss_inc   = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Saturating hit/miss statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc && (hit_count != '1)) begin
            hit_count <= hit_count + CNT_W'(1);
         end
         if (miss_inc && (miss_count != '1)) begin
            miss_count <= miss_count + CNT_W'(1);
         end
      end
   end

endmodule
